// File: rtl/memory_arbiter_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
// State encoding, requester IDs and counter width.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int CNT_W = 32;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two cache refill paths, memory and the arbiter.
// slave = arbiter view, master = caches/memory/environment view.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                icache_mem_req;
    logic [ADDR_W-1:0]   icache_mem_addr;
    logic [DATA_W-1:0]   icache_mem_rdata;
    logic                icache_mem_ready;

    logic                dcache_mem_req;
    logic [ADDR_W-1:0]   dcache_mem_addr;
    logic [DATA_W-1:0]   dcache_mem_wdata;
    logic [DATA_W/8-1:0] dcache_mem_be;
    logic                dcache_mem_we;
    logic [DATA_W-1:0]   dcache_mem_rdata;
    logic                dcache_mem_ready;

    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ready;

    logic [31:0]         stat_icache_grants;
    logic [31:0]         stat_dcache_grants;
    logic [31:0]         stat_conflicts;

    modport slave (
        input  icache_mem_req, icache_mem_addr,
        output icache_mem_rdata, icache_mem_ready,
        input  dcache_mem_req, dcache_mem_addr,
        input  dcache_mem_wdata, dcache_mem_be, dcache_mem_we,
        output dcache_mem_rdata, dcache_mem_ready,
        output mem_req, mem_addr, mem_wdata, mem_be, mem_we,
        input  mem_rdata, mem_ready,
        output stat_icache_grants, stat_dcache_grants,
        output stat_conflicts
    );

    modport master (
        output icache_mem_req, icache_mem_addr,
        input  icache_mem_rdata, icache_mem_ready,
        output dcache_mem_req, dcache_mem_addr,
        output dcache_mem_wdata, dcache_mem_be, dcache_mem_we,
        input  dcache_mem_rdata, dcache_mem_ready,
        input  mem_req, mem_addr, mem_wdata, mem_be, mem_we,
        output mem_rdata, mem_ready,
        input  stat_icache_grants, stat_dcache_grants,
        input  stat_conflicts
    );

endinterface

// File: rtl/memory_arbiter_stats.sv
// Saturating contention counters for the memory arbiter.
// Only instantiated when MEMORY_ARBITER_STATS_EN is defined.
module memory_arbiter_stats
    import memory_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             inc_d,
    input  logic             inc_c,
    output logic [CNT_W-1:0] icache_grants,
    output logic [CNT_W-1:0] dcache_grants,
    output logic [CNT_W-1:0] conflicts
);

    logic [CNT_W-1:0] icache_cnt_q, icache_cnt_d;
    logic [CNT_W-1:0] dcache_cnt_q, dcache_cnt_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        icache_cnt_d   = icache_cnt_q;
        dcache_cnt_d   = dcache_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (inc_i) icache_cnt_d   = sat_inc(icache_cnt_q);
        if (inc_d) dcache_cnt_d   = sat_inc(dcache_cnt_q);
        if (inc_c) conflict_cnt_d = sat_inc(conflict_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icache_cnt_q   <= '0;
            dcache_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            icache_cnt_q   <= icache_cnt_d;
            dcache_cnt_q   <= dcache_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign icache_grants = icache_cnt_q;
    assign dcache_grants = dcache_cnt_q;
    assign conflicts     = conflict_cnt_q;

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing main memory between I- and D-cache refills.
// Define MEMORY_ARBITER_STATS_EN to build the contention counters.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input logic              clk,
    input logic              rst,
    memory_arbiter_if.slave  bus
);

    state_e state_q, state_d;
    logic   last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        last_d               = last_q;
        bus.mem_req          = 1'b0;
        bus.mem_addr         = '0;
        bus.mem_wdata        = '0;
        bus.mem_be           = '0;
        bus.mem_we           = 1'b0;
        bus.icache_mem_ready = 1'b0;
        bus.dcache_mem_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ties go to whoever did not win last time.
                if (bus.icache_mem_req && bus.dcache_mem_req)
                    state_d = (last_q == REQ_D) ? GRANT_I : GRANT_D;
                else if (bus.icache_mem_req)
                    state_d = GRANT_I;
                else if (bus.dcache_mem_req)
                    state_d = GRANT_D;
            end
            GRANT_I: begin
                last_d       = REQ_I;
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.icache_mem_addr;
                bus.mem_be   = '1;
                if (bus.mem_ready) begin
                    bus.icache_mem_ready = 1'b1;
                    state_d              = IDLE;
                end
            end
            GRANT_D: begin
                last_d        = REQ_D;
                bus.mem_req   = 1'b1;
                bus.mem_addr  = bus.dcache_mem_addr;
                bus.mem_wdata = bus.dcache_mem_wdata;
                bus.mem_be    = bus.dcache_mem_be;
                bus.mem_we    = bus.dcache_mem_we;
                if (bus.mem_ready) begin
                    bus.dcache_mem_ready = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.icache_mem_rdata = bus.mem_rdata;
    assign bus.dcache_mem_rdata = bus.mem_rdata;

`ifdef MEMORY_ARBITER_STATS_EN
    logic inc_i, inc_d, inc_c;

    assign inc_i = (state_q == IDLE) && (state_d == GRANT_I);
    assign inc_d = (state_q == IDLE) && (state_d == GRANT_D);
    assign inc_c = (state_q == IDLE) &&
                   bus.icache_mem_req && bus.dcache_mem_req;

    memory_arbiter_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .inc_i         (inc_i),
        .inc_d         (inc_d),
        .inc_c         (inc_c),
        .icache_grants (bus.stat_icache_grants),
        .dcache_grants (bus.stat_dcache_grants),
        .conflicts     (bus.stat_conflicts)
    );
`else
    assign bus.stat_icache_grants = '0;
    assign bus.stat_dcache_grants = '0;
    assign bus.stat_conflicts     = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus
// sequences for alternation, mid-transaction reset and saturation.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        dwe;
        logic [31:0] mrd;
        logic        mrdy;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_mwd;
        logic        e_irdy;
        logic        e_drdy;
    } vec_t;

    function automatic vec_t v(
        logic ireq, logic [31:0] iaddr,
        logic dreq, logic [31:0] daddr,
        logic [31:0] dwd, logic [3:0] dbe, logic dwe,
        logic [31:0] mrd, logic mrdy,
        logic e_mreq, logic [31:0] e_maddr, logic e_mwe,
        logic [3:0] e_mbe, logic [31:0] e_mwd,
        logic e_irdy, logic e_drdy
    );
        vec_t r;
        r.ireq = ireq;     r.iaddr = iaddr;
        r.dreq = dreq;     r.daddr = daddr;
        r.dwd = dwd;       r.dbe = dbe;     r.dwe = dwe;
        r.mrd = mrd;       r.mrdy = mrdy;
        r.e_mreq = e_mreq; r.e_maddr = e_maddr;
        r.e_mwe = e_mwe;   r.e_mbe = e_mbe; r.e_mwd = e_mwd;
        r.e_irdy = e_irdy; r.e_drdy = e_drdy;
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.icache_mem_req   = 1'b0;
        bus.icache_mem_addr  = '0;
        bus.dcache_mem_req   = 1'b0;
        bus.dcache_mem_addr  = '0;
        bus.dcache_mem_wdata = '0;
        bus.dcache_mem_be    = '0;
        bus.dcache_mem_we    = 1'b0;
        bus.mem_rdata        = '0;
        bus.mem_ready        = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with rst low and the arbiter idle.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_irdy", 32'(bus.icache_mem_ready), 32'd0);
        chk("rst_drdy", 32'(bus.dcache_mem_ready), 32'd0);
        chk("rst_stat_i", bus.stat_icache_grants, 32'd0);
        chk("rst_stat_d", bus.stat_dcache_grants, 32'd0);
        chk("rst_stat_c", bus.stat_conflicts, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_req actual=timeout required=mem_req");
        end
    endtask

    task automatic run_i_txn();
        bit ok;
        bus.icache_mem_req  = 1'b1;
        bus.icache_mem_addr = 32'h0000_0700;
        wait_req(ok);
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        bus.icache_mem_req = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] s_i, s_d, s_c;

        tbl[0]  = v(1, 32'h300, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'h0, 0,
                    0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        tbl[1]  = v(1, 32'h300, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'h0, 0,
                    1, 32'h300, 0, 4'hF, 32'h0, 0, 0);
        tbl[2]  = v(1, 32'h300, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'hAAAA_0001, 1,
                    1, 32'h300, 0, 4'hF, 32'h0, 1, 0);
        tbl[3]  = v(0, 32'h0, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'h0, 0,
                    0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        tbl[4]  = v(0, 32'h0, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'h0, 0,
                    1, 32'h200, 1, 4'h3, 32'h1234, 0, 0);
        tbl[5]  = v(0, 32'h0, 1, 32'h200, 32'h1234, 4'h3, 1,
                    32'h55, 1,
                    1, 32'h200, 1, 4'h3, 32'h1234, 0, 1);
        tbl[6]  = v(1, 32'h100, 0, 32'h0, 32'h0, 4'h0, 0,
                    32'h0, 0,
                    0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        tbl[7]  = v(1, 32'h100, 0, 32'h0, 32'h0, 4'h0, 0,
                    32'h0, 0,
                    1, 32'h100, 0, 4'hF, 32'h0, 0, 0);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = v(1, 32'h100, 0, 32'h0, 32'h0, 4'h0, 0,
                    32'hDEAD_BEEF, 1,
                    1, 32'h100, 0, 4'hF, 32'h0, 1, 0);
        tbl[11] = v(0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0,
                    32'hCAFE, 1,
                    0, 32'h0, 0, 4'h0, 32'h0, 0, 0);

        do_reset();

        for (int i = 0; i < 12; i++) begin
            bus.icache_mem_req   = tbl[i].ireq;
            bus.icache_mem_addr  = tbl[i].iaddr;
            bus.dcache_mem_req   = tbl[i].dreq;
            bus.dcache_mem_addr  = tbl[i].daddr;
            bus.dcache_mem_wdata = tbl[i].dwd;
            bus.dcache_mem_be    = tbl[i].dbe;
            bus.dcache_mem_we    = tbl[i].dwe;
            bus.mem_rdata        = tbl[i].mrd;
            bus.mem_ready        = tbl[i].mrdy;
            @(negedge clk);
            chk($sformatf("v%0d_mem_req", i),
                32'(bus.mem_req), 32'(tbl[i].e_mreq));
            chk($sformatf("v%0d_mem_addr", i),
                bus.mem_addr, tbl[i].e_maddr);
            chk($sformatf("v%0d_mem_we", i),
                32'(bus.mem_we), 32'(tbl[i].e_mwe));
            chk($sformatf("v%0d_mem_be", i),
                32'(bus.mem_be), 32'(tbl[i].e_mbe));
            chk($sformatf("v%0d_mem_wdata", i),
                bus.mem_wdata, tbl[i].e_mwd);
            chk($sformatf("v%0d_irdy", i),
                32'(bus.icache_mem_ready), 32'(tbl[i].e_irdy));
            chk($sformatf("v%0d_drdy", i),
                32'(bus.dcache_mem_ready), 32'(tbl[i].e_drdy));
            chk($sformatf("v%0d_irdata", i),
                bus.icache_mem_rdata, tbl[i].mrd);
            chk($sformatf("v%0d_drdata", i),
                bus.dcache_mem_rdata, tbl[i].mrd);
            @(posedge clk);
            #1;
        end
        clear_inputs();
        @(negedge clk);
`ifdef MEMORY_ARBITER_STATS_EN
        s_i = 32'd2; s_d = 32'd1; s_c = 32'd1;
`else
        s_i = 32'd0; s_d = 32'd0; s_c = 32'd0;
`endif
        chk("tbl_stat_i", bus.stat_icache_grants, s_i);
        chk("tbl_stat_d", bus.stat_dcache_grants, s_d);
        chk("tbl_stat_c", bus.stat_conflicts, s_c);

        // Both requesters held: grants must alternate starting with I.
        do_reset();
        bus.icache_mem_req   = 1'b1;
        bus.icache_mem_addr  = 32'h400;
        bus.dcache_mem_req   = 1'b1;
        bus.dcache_mem_addr  = 32'h500;
        bus.dcache_mem_wdata = 32'h9999;
        bus.dcache_mem_be    = 4'hF;
        bus.dcache_mem_we    = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_req(ok);
            if (!ok) break;
            chk($sformatf("alt%0d_addr", t), bus.mem_addr,
                (t % 2 == 0) ? 32'h400 : 32'h500);
            @(posedge clk);
            #1 bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'(t);
            @(negedge clk);
            chk($sformatf("alt%0d_irdy", t),
                32'(bus.icache_mem_ready), (t % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_drdy", t),
                32'(bus.dcache_mem_ready), (t % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1 bus.mem_ready = 1'b0;
        end
        bus.icache_mem_req = 1'b0;
        bus.dcache_mem_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
`ifdef MEMORY_ARBITER_STATS_EN
        s_i = 32'd3; s_d = 32'd3; s_c = 32'd6;
`else
        s_i = 32'd0; s_d = 32'd0; s_c = 32'd0;
`endif
        chk("alt_stat_i", bus.stat_icache_grants, s_i);
        chk("alt_stat_d", bus.stat_dcache_grants, s_d);
        chk("alt_stat_c", bus.stat_conflicts, s_c);

        // Reset while GRANT_D waits on memory; late ready is ignored.
        @(posedge clk);
        #1;
        do_reset();
        bus.dcache_mem_req   = 1'b1;
        bus.dcache_mem_addr  = 32'h600;
        bus.dcache_mem_we    = 1'b1;
        bus.dcache_mem_be    = 4'hF;
        wait_req(ok);
        chk("rstmid_we", 32'(bus.mem_we), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.dcache_mem_req = 1'b0;
        bus.mem_ready      = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstmid_drdy", 32'(bus.dcache_mem_ready), 32'd0);
        chk("rstmid_irdy", 32'(bus.icache_mem_ready), 32'd0);
        chk("rstmid_stat_d", bus.stat_dcache_grants, 32'd0);
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", 32'(bus.mem_req), 32'd0);

`ifdef MEMORY_ARBITER_STATS_EN
        @(posedge clk);
        #1;
        do_reset();
        force dut.u_stats.icache_cnt_q = 32'hFFFF_FFFE;
        release dut.u_stats.icache_cnt_q;
        run_i_txn();
        run_i_txn();
        @(negedge clk);
        chk("sat_stat_i", bus.stat_icache_grants, 32'hFFFF_FFFF);
`else
        @(posedge clk);
        #1;
        run_i_txn();
        @(negedge clk);
        chk("nostat_stat_i", bus.stat_icache_grants, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. It sits between both caches and the main memory model. It grants one transaction at a time, uses round-robin priority on conflicts, and holds the grant until memory signals completion. Optional statistics counters expose contention for performance analysis.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `icache_mem_req`  in  1  I-cache transaction request; held until `icache_mem_ready`.
- `icache_mem_addr`  in  ADDR_W  I-cache read address.
- `icache_mem_rdata`  out  DATA_W  read data to the I-cache.
- `icache_mem_ready`  out  1  one-cycle completion pulse to the I-cache.
- `dcache_mem_req`  in  1  D-cache transaction request; held until `dcache_mem_ready`.
- `dcache_mem_addr`  in  ADDR_W  D-cache address.
- `dcache_mem_wdata`  in  DATA_W  D-cache write data.
- `dcache_mem_be`  in  DATA_W/8  D-cache byte enables.
- `dcache_mem_we`  in  1  D-cache write (1) or read (0).
- `dcache_mem_rdata`  out  DATA_W  read data to the D-cache.
- `dcache_mem_ready`  out  1  one-cycle completion pulse to the D-cache.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_addr`  out  ADDR_W  address to memory.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_be`  out  DATA_W/8  byte enables to memory.
- `mem_we`  out  1  write enable to memory.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  memory completion, asserted for one cycle.
- `stat_icache_grants`  out  32  number of I-cache grants.
- `stat_dcache_grants`  out  32  number of D-cache grants.
- `stat_conflicts`  out  32  number of IDLE cycles with both requests high.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE, only `icache_mem_req` high: go to GRANT_I.
- IDLE, only `dcache_mem_req` high: go to GRANT_D.
- IDLE, both high: grant the requester opposite to `last_grant`.
- IDLE, neither high: stay in IDLE.
- In either GRANT state, `last_grant` is updated to the granted requester.
- In GRANT_x:
  - `mem_req` is 1.
  - `mem_addr`, `mem_wdata`, `mem_be`, `mem_we` are muxed combinationally from the granted requester.
  - For I-cache grants, `mem_we` is 0 and `mem_be` is all ones.
- GRANT_x with `mem_ready` = 1:
  - Pulse `x_mem_ready` in the same cycle.
  - Pass `mem_rdata` through to `x_mem_rdata`.
  - Return to IDLE.
- The ungranted requester's ready signal is always 0.
- `*_mem_rdata` outputs carry `mem_rdata` unconditionally; they are meaningful only with the corresponding ready pulse.
- After every completion the FSM spends one mandatory IDLE cycle. A requester still holding req in that cycle is treated as a new transaction.
- Starvation bound: a waiting requester is granted after at most one transaction of the other requester.
- A request that drops while ungranted is simply not served. Dropping req while granted is a protocol violation, and the grant is held regardless.

## Timing
- Reset values:
  - State IDLE; `last_grant` = D, so the I-cache wins the first tie.
  - `mem_req` = 0; `mem_we` = 0.
  - Both ready outputs = 0.
  - All statistics counters = 0.
- Grant latency: req sampled in IDLE at edge N means `mem_req` = 1 from cycle N+1.
- Completion is combinational (`mem_ready` to `x_mem_ready`, zero cycles).
- Back-to-back throughput: one transaction per (memory latency + 2) cycles minimum.
- Reset asserted mid-transaction:
  - Next cycle the FSM is IDLE with `mem_req` = 0.
  - The in-flight memory transaction is abandoned, and memory must tolerate a dropped request.
  - A `mem_ready` arriving while in IDLE is ignored, and no ready pulse is generated.

## Configuration
- `MEMORY_ARBITER_STATS_EN` defined:
  - Three 32-bit saturating counters (hold at 0xFFFFFFFF).
  - The grant counters increment on each IDLE→GRANT transition.
  - The conflict counter increments each IDLE cycle with both requests high.
  - All counters are cleared by `rst`.
- Macro not defined: the three stat outputs are tied to 0 and no counter flops exist.

## Structure
- Shared package: FSM state encoding (IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2), requester ID constants (REQ_I = 1'b0, REQ_D = 1'b1), counter width constant.
- Sub-module `memory_arbiter_stats` holds the three saturating counters. It is instantiated only under `MEMORY_ARBITER_STATS_EN`.

## Test plan
- I-cache read only, addr 0x100, memory latency 3 → `mem_req` high cycles 1–4 with `mem_addr` = 0x100, `mem_we` = 0; `icache_mem_ready` pulses once in cycle 4 with rdata 0xDEADBEEF.
- Simultaneous I/D requests after reset → I granted first; D granted in the IDLE cycle after I completes (D addr 0x200, we = 1, be = 0x3, wdata 0x1234 seen on memory); `stat_conflicts` ≥ 1.
- Both requests held continuously for 6 transactions → grants alternate I, D, I, D, I, D; `stat_icache_grants` = 3 and `stat_dcache_grants` = 3.
- Reset asserted during GRANT_D with memory still busy → next cycle `mem_req` = 0 and state IDLE; a late `mem_ready` produces no `dcache_mem_ready`; counters read 0.
- Build without `MEMORY_ARBITER_STATS_EN`, repeat the alternation test → functional behaviour identical; all stat outputs read 0.
- Saturation, with `MEMORY_ARBITER_STATS_EN` built and the counter forced to 0xFFFFFFFE → two more I grants leave `stat_icache_grants` = 0xFFFFFFFF.
